// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: 2-flop synchroniser, oversampled bit timing with a
// three-sample majority vote per bit, and one-cycle data/framing-error strobes.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 BRclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_STATUS,
  output logic                 FRAME_ERR,
  output logic                 RX_BUSY
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam int unsigned B_W  = $clog2(DATA_BITS + 2);

  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]  B_LAST  = B_W'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [B_W-1:0]         b_q, b_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   status_q, status_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;

  logic                   rx_s;
  logic                   maj;
  logic                   decide;
  logic [PH_W-1:0]        ph_inc;

  assign rx_s = sync2_q;

  // Third sample is taken live at the decision phase, the first two are stored.
  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign decide = (ph_q == PH_DEC);
  assign ph_inc = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);

  always_ff @(posedge BRclk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= IDLE;
      ph_q     <= '0;
      b_q      <= '0;
      shift_q  <= '0;
      smp_q    <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q  <= UART_RX;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      ph_q     <= ph_d;
      b_q      <= b_d;
      shift_q  <= shift_d;
      smp_q    <= smp_d;
      data_q   <= data_d;
      status_q <= status_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    b_d      = b_q;
    shift_d  = shift_q;
    smp_d    = smp_q;
    data_d   = data_q;
    status_d = 1'b0;
    ferr_d   = 1'b0;

    if (ph_q == PH_S0) smp_d[0] = rx_s;
    if (ph_q == PH_S1) smp_d[1] = rx_s;

    unique case (state_q)
      IDLE: begin
        ph_d = '0;
        b_d  = '0;
        if (!rx_s) begin
          state_d = START;
          ph_d    = PH_W'(1);
        end
      end
      START: begin
        ph_d = ph_inc;
        if (decide && maj) begin
          state_d = IDLE;
          ph_d    = '0;
        end else if (ph_q == PH_LAST) begin
          state_d = DATA;
          b_d     = B_W'(1);
        end
      end
      DATA: begin
        ph_d = ph_inc;
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (ph_q == PH_LAST) begin
          b_d = b_q + B_W'(1);
          if (b_q == B_LAST) state_d = STOP;
        end
      end
      STOP: begin
        ph_d = ph_inc;
        // Leave at the stop-bit centre so a following start edge is not missed.
        if (decide) begin
          ph_d = '0;
          if (maj) begin
            data_d   = shift_q;
            status_d = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        ph_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign RX_DATA   = data_q;
  assign RX_STATUS = status_q;
  assign FRAME_ERR = ferr_q;
  assign RX_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames are driven on the serial line,
// expected bytes/strobe times queued at send time and matched against observed strobes.
module tb_uart_receiver;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       BRclk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       FRAME_ERR;
  logic       RX_BUSY;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  viol = 0;
  int  busy_rise = -1;
  int  busy_fall = -1;
  logic strobe_prev = 1'b0;
  logic busy_prev = 1'b0;

  ev_t exp_q[$];
  ev_t got_q[$];
  int  exp_ferr_q[$];
  int  got_ferr_q[$];

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .BRclk    (BRclk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .RX_DATA  (RX_DATA),
    .RX_STATUS(RX_STATUS),
    .FRAME_ERR(FRAME_ERR),
    .RX_BUSY  (RX_BUSY)
  );

  always #5 BRclk = ~BRclk;

  always @(posedge BRclk) cyc <= cyc + 1;

  // Observe outputs mid-cycle and log strobes and busy transitions.
  always @(negedge BRclk) begin
    ev_t e;
    if (RX_STATUS === 1'b1) begin
      e.data = RX_DATA;
      e.cyc  = cyc;
      got_q.push_back(e);
    end
    if (FRAME_ERR === 1'b1) got_ferr_q.push_back(cyc);
    if (RX_STATUS === 1'b1 && FRAME_ERR === 1'b1) viol++;
    if ((RX_STATUS === 1'b1 || FRAME_ERR === 1'b1) && strobe_prev) viol++;
    if (RX_BUSY === 1'b1 && busy_prev === 1'b0) busy_rise = cyc;
    if (RX_BUSY === 1'b0 && busy_prev === 1'b1) busy_fall = cyc;
    strobe_prev = (RX_STATUS === 1'b1) || (FRAME_ERR === 1'b1);
    busy_prev   = (RX_BUSY === 1'b1);
  end

  // Drive one 8N1 frame; must be called right after a negedge.
  task automatic send_frame(input logic [7:0] d, input int bitlen, input logic stop_v,
                            input bit exact, output int t0);
    logic [9:0] bits;
    ev_t e;
    bits = {stop_v, d, 1'b0};
    t0 = cyc;
    if (stop_v) begin
      e.data = d;
      e.cyc  = exact ? t0 + 156 : -1;
      exp_q.push_back(e);
    end else begin
      exp_ferr_q.push_back(t0 + 156);
    end
    for (int i = 0; i < 10; i++) begin
      UART_RX = bits[i];
      repeat (bitlen) @(negedge BRclk);
    end
    UART_RX = 1'b1;
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(negedge BRclk);
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1;
    UART_RX = 1'b1;
    repeat (3) @(negedge BRclk);
    vectors++;
    if ({RX_DATA, RX_STATUS, FRAME_ERR, RX_BUSY} !== 11'h0) begin
      $display("FAIL reset_values: got data=%h st=%b fe=%b busy=%b want all 0",
               RX_DATA, RX_STATUS, FRAME_ERR, RX_BUSY);
      miscompares++;
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge BRclk);
      if ({RX_STATUS, FRAME_ERR, RX_BUSY} !== 3'b000) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      $display("FAIL idle_quiet: %0d cycles with a strobe/busy, want 0", bad);
      miscompares++;
    end
    vectors++;
    if (RX_DATA !== 8'h00) begin
      $display("FAIL idle_data: got %h want 00", RX_DATA);
      miscompares++;
    end
  endtask

  task automatic test_single;
    int t0;
    ev_t g, x;
    send_frame(8'h55, 16, 1'b1, 1'b1, t0);
    idle(20);
    vectors++;
    if (busy_rise !== t0 + 3) begin
      $display("FAIL single_busy_rise: got %0d want %0d", busy_rise, t0 + 3);
      miscompares++;
    end
    vectors++;
    if (busy_fall !== t0 + 156) begin
      $display("FAIL single_busy_fall: got %0d want %0d", busy_fall, t0 + 156);
      miscompares++;
    end
    vectors++;
    if (got_ferr_q.size() !== 0) begin
      $display("FAIL single_ferr: got %0d frame errors want 0", got_ferr_q.size());
      miscompares++;
    end
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL single_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
      miscompares++;
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.data !== x.data || g.cyc !== x.cyc) begin
        $display("FAIL single_byte: got %h@%0d want %h@%0d", g.data, g.cyc, x.data, x.cyc);
        miscompares++;
      end
    end
    exp_q.delete(); got_q.delete(); got_ferr_q.delete();
  endtask

  task automatic test_back_to_back;
    int t0, t1;
    ev_t g, x;
    send_frame(8'hA3, 16, 1'b1, 1'b1, t0);
    send_frame(8'h0F, 16, 1'b1, 1'b1, t1);
    idle(20);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL b2b_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
      miscompares++;
    end else begin
      vectors++;
      if (got_q[1].cyc - got_q[0].cyc !== 160) begin
        $display("FAIL b2b_spacing: got %0d want 160", got_q[1].cyc - got_q[0].cyc);
        miscompares++;
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.data !== x.data || g.cyc !== x.cyc) begin
        $display("FAIL b2b_byte: got %h@%0d want %h@%0d", g.data, g.cyc, x.data, x.cyc);
        miscompares++;
      end
    end
    vectors++;
    if (RX_DATA !== 8'h0F) begin
      $display("FAIL b2b_hold: got %h want 0f", RX_DATA);
      miscompares++;
    end
    exp_q.delete(); got_q.delete(); got_ferr_q.delete();
  endtask

  task automatic test_glitch;
    int t0;
    UART_RX = 1'b0;
    t0 = cyc;
    repeat (4) @(negedge BRclk);
    idle(40);
    vectors++;
    if (got_q.size() !== 0 || got_ferr_q.size() !== 0) begin
      $display("FAIL glitch_strobe: got %0d data / %0d err strobes want 0/0",
               got_q.size(), got_ferr_q.size());
      miscompares++;
    end
    vectors++;
    if (busy_rise !== t0 + 3 || busy_fall !== t0 + 12) begin
      $display("FAIL glitch_busy: got rise %0d fall %0d want %0d %0d",
               busy_rise, busy_fall, t0 + 3, t0 + 12);
      miscompares++;
    end
    vectors++;
    if (RX_DATA !== 8'h0F) begin
      $display("FAIL glitch_hold: got %h want 0f", RX_DATA);
      miscompares++;
    end
    got_q.delete(); got_ferr_q.delete();
  endtask

  task automatic test_frame_err;
    int t0, xf;
    ev_t g, x;
    send_frame(8'h81, 16, 1'b0, 1'b1, t0);
    UART_RX = 1'b0;
    repeat (300) @(negedge BRclk);
    idle(30);
    vectors++;
    if (got_ferr_q.size() !== 1) begin
      $display("FAIL ferr_count: got %0d want 1", got_ferr_q.size());
      miscompares++;
    end
    while (exp_ferr_q.size() > 0 && got_ferr_q.size() > 0) begin
      xf = exp_ferr_q.pop_front();
      vectors++;
      if (got_ferr_q[0] !== xf) begin
        $display("FAIL ferr_time: got %0d want %0d", got_ferr_q[0], xf);
        miscompares++;
      end
      void'(got_ferr_q.pop_front());
    end
    vectors++;
    if (got_q.size() !== 0 || RX_DATA !== 8'h0F) begin
      $display("FAIL ferr_data: got %0d strobes data %h want 0 strobes data 0f",
               got_q.size(), RX_DATA);
      miscompares++;
    end
    got_q.delete();
    send_frame(8'h3C, 16, 1'b1, 1'b1, t0);
    idle(20);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL ferr_recover_count: got %0d want %0d", got_q.size(), exp_q.size());
      miscompares++;
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.data !== x.data || g.cyc !== x.cyc) begin
        $display("FAIL ferr_recover_byte: got %h@%0d want %h@%0d", g.data, g.cyc, x.data, x.cyc);
        miscompares++;
      end
    end
    exp_q.delete(); got_q.delete(); exp_ferr_q.delete(); got_ferr_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    int t0;
    ev_t g, x;
    bits = {1'b1, 8'hFF, 1'b0};
    for (int k = 0; k < 160; k++) begin
      UART_RX = bits[k / 16];
      reset   = (k == 72);
      @(negedge BRclk);
      if (k == 72) begin
        vectors++;
        if (RX_BUSY !== 1'b0 || RX_DATA !== 8'h00) begin
          $display("FAIL midreset_values: got busy=%b data=%h want 0 00", RX_BUSY, RX_DATA);
          miscompares++;
        end
      end
    end
    reset = 1'b0;
    idle(20);
    vectors++;
    if (got_q.size() !== 0 || got_ferr_q.size() !== 0) begin
      $display("FAIL midreset_strobe: got %0d/%0d strobes want 0/0",
               got_q.size(), got_ferr_q.size());
      miscompares++;
    end
    send_frame(8'h12, 16, 1'b1, 1'b1, t0);
    idle(20);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL midreset_count: got %0d want %0d", got_q.size(), exp_q.size());
      miscompares++;
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.data !== x.data || g.cyc !== x.cyc) begin
        $display("FAIL midreset_byte: got %h@%0d want %h@%0d", g.data, g.cyc, x.data, x.cyc);
        miscompares++;
      end
    end
    exp_q.delete(); got_q.delete(); got_ferr_q.delete();
  endtask

  task automatic test_baud_skew;
    int t0;
    ev_t g, x;
    send_frame(8'hC5, 15, 1'b1, 1'b0, t0);
    idle(30);
    send_frame(8'hC5, 17, 1'b1, 1'b0, t0);
    idle(30);
    vectors++;
    if (got_q.size() !== exp_q.size() || got_ferr_q.size() !== 0) begin
      $display("FAIL skew_count: got %0d strobes %0d errs want %0d 0",
               got_q.size(), got_ferr_q.size(), exp_q.size());
      miscompares++;
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.data !== x.data) begin
        $display("FAIL skew_byte: got %h want %h", g.data, x.data);
        miscompares++;
      end
    end
    exp_q.delete(); got_q.delete(); got_ferr_q.delete();
  endtask

  initial begin
    @(negedge BRclk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_baud_skew();
    vectors++;
    if (viol !== 0) begin
      $display("FAIL strobe_rules: got %0d overlapping/consecutive strobes want 0", viol);
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
